dsc_mul_seq: RTL and testbench

- Operand sequencer and result-capture stage wrapped around one DSC serial multiplier instance, e.g. a stride-2 multiply core.
- Accepts a packed operand word through a valid/ready handshake and holds the operands stable on the multiplier inputs.
- Clears the multiplier, runs it until its done flag rises, then captures the accumulated binary product and presents it downstream through a valid/ready handshake.
- Gives the architecture-sweep harness a streaming interface and per-operation cycle counts.

---
 rtl/dsc_mul_seq.sv | 182 ++++++++++++++++++
 tb/tb_dsc_mul_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: operand sequencer and result capture around one DSC serial multiplier.
// Latency 1 + CLR_CYCLES + run + SETTLE_CYCLES edges from input handshake to out_valid; one operation in flight.
// in_ready is low from accept until the result handshake; the result holds while out_ready is low. Macro: DSC_MUL_SEQ_ZERO_BYPASS_EN.
module dsc_mul_seq #(
    parameter int  DATA_WIDTH    = 5,
    parameter int  NUM_INPUTS    = 2,
    parameter int  CLR_CYCLES    = 2,
    parameter int  SETTLE_CYCLES = 1,
    parameter int  MAX_CYCLES    = 4096,
    localparam int CNT_W         = $clog2(MAX_CYCLES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                             mul_rst,
    output logic                             mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data_out,
    input  logic                             mul_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                 out_cycles,
    output logic                             out_timeout
);

    localparam int DW     = NUM_INPUTS * DATA_WIDTH;
    localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [PH_W-1:0]  CLR_LAST = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]  SET_LAST = PH_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_done_q;
    logic              r_timeout;
    logic [DW-1:0]     r_opnd;
    logic [DW-1:0]     r_out_data;
    logic [CNT_W-1:0]  r_out_cycles;
    logic              r_out_timeout;

    logic              w_accept;
    logic              w_capture;
    logic              w_bypass;
    logic              w_done_rise;
    logic              w_run_end;

`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
    always_comb begin
        w_bypass = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) begin
                w_bypass = 1'b1;
            end
        end
    end
`else
    assign w_bypass = 1'b0;
`endif

    // Saturating run counter; the limit check looks at the value this cycle will leave behind.
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_done_rise = mul_done & ~r_done_q;
    assign w_run_end   = w_done_rise | (w_cnt_inc == CNT_MAX);

    assign mul_rst     = rst | (r_state == S_CLEAR);
    assign mul_data_in = r_opnd;
    assign out_data    = r_out_data;
    assign out_cycles  = r_out_cycles;
    assign out_timeout = r_out_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mul_en      = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_bypass ? S_HOLD : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_phase == CLR_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                mul_en = ~rst;
                if (w_run_end) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_phase == SET_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = ~rst;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= '0;
            r_cnt         <= '0;
            r_done_q      <= 1'b0;
            r_timeout     <= 1'b0;
            r_opnd        <= '0;
            r_out_data    <= '0;
            r_out_cycles  <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            if (r_state != w_state_nxt) begin
                r_phase <= '0;
            end else if (r_state == S_CLEAR || r_state == S_SETTLE) begin
                r_phase <= r_phase + PH_W'(1);
            end

            // Outside RUN the copy is held low, so a done already high on entry reads as a rising edge.
            r_done_q <= (r_state == S_RUN) ? mul_done : 1'b0;

            if (w_accept) begin
                r_opnd <= in_data;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= w_cnt_inc;
            end

            if (r_state == S_RUN && w_run_end) begin
                r_timeout <= ~w_done_rise;
            end

            if (w_capture) begin
                r_out_data    <= mul_data_out;
                r_out_cycles  <= r_cnt;
                r_out_timeout <= r_timeout;
            end else if (w_accept && w_bypass) begin
                r_out_data    <= '0;
                r_out_cycles  <= '0;
                r_out_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: behavioural multiplier model plus a rule-level reference for every operation.
module tb_dsc_mul_seq;

    localparam int W    = 5;
    localparam int NI   = 2;
    localparam int DW   = W * NI;
    localparam int CLR  = 2;
    localparam int SETL = 1;
    localparam int MAXC = 16;
    localparam int CW   = $clog2(MAXC + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          mul_rst;
    logic          mul_en;
    logic [DW-1:0] mul_data_in;
    logic [DW-1:0] mul_data_out;
    logic          mul_done;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_cycles;
    logic          out_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            edges;
        int            rst_c;
        int            en_c;
        int            busy_rdy;
        int            unstable;
        int            wait_rdy;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        logic          ot;
        logic [DW-1:0] mdi;
        logic          post_valid;
        logic          post_rdy;
    } obs_t;

    dsc_mul_seq #(
        .DATA_WIDTH   (W),
        .NUM_INPUTS   (NI),
        .CLR_CYCLES   (CLR),
        .SETTLE_CYCLES(SETL),
        .MAX_CYCLES   (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mul_rst     (mul_rst),
        .mul_en      (mul_en),
        .mul_data_in (mul_data_in),
        .mul_data_out(mul_data_out),
        .mul_done    (mul_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cycles  (out_cycles),
        .out_timeout (out_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: done (level) is visible from the model_lat-th enabled cycle onward;
    // before that the output shows the number of enabled cycles seen so far.
    int            m_cnt = 0;
    int            model_lat = 1;
    logic [DW-1:0] model_prod = '0;

    always @(posedge clk) begin
        if (mul_rst) m_cnt <= 0;
        else if (mul_en) m_cnt <= m_cnt + 1;
    end

    always_comb begin
        mul_done     = (m_cnt + 1 >= model_lat);
        mul_data_out = mul_done ? model_prod : DW'(m_cnt);
    end

    function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] d);
        longint p;
        p = 1;
        for (int i = 0; i < NI; i++) p = p * longint'(d[i*W +: W]);
        return DW'(p);
    endfunction

    function automatic void ref_op(input logic [DW-1:0] d, input int l,
                                   output int e_edges, output int e_en, output int e_rst,
                                   output logic [DW-1:0] e_data, output int e_cyc, output logic e_to);
        int run;
        run     = (l < MAXC) ? l : MAXC;
        e_to    = (l > MAXC);
        e_data  = (run + 1 >= l) ? ref_prod(d) : DW'(run);
        e_cyc   = run;
        e_en    = run;
        e_rst   = CLR;
        e_edges = 1 + CLR + run + SETL;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
        for (int i = 0; i < NI; i++) begin
            if (d[i*W +: W] == '0) begin
                e_edges = 1; e_en = 0; e_rst = 0; e_data = '0; e_cyc = 0; e_to = 1'b0;
            end
        end
`endif
    endfunction

    // Runs one operation from a negedge with the sequencer idle; ends on the negedge after the result handshake.
    task automatic do_op(input logic [DW-1:0] d, input int l, input int stall, output obs_t o);
        int guard;
        o = '{default: 0};
        model_lat  = l;
        model_prod = ref_prod(d);
        in_data    = d;
        in_valid   = 1'b1;
        guard      = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        o.wait_rdy = guard;
        @(posedge clk);
        o.edges = 1;
        @(negedge clk);
        o.mdi = mul_data_in;
        while (!out_valid && o.edges < 200) begin
            o.rst_c    += int'(mul_rst);
            o.en_c     += int'(mul_en);
            o.busy_rdy += int'(in_ready);
            if (mul_data_in !== d) o.unstable++;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            @(negedge clk);
            o.edges++;
        end
        if (!out_valid) o.edges = -1;
        in_valid = 1'b0;
        o.od = out_data;
        o.oc = out_cycles;
        o.ot = out_timeout;
        for (int k = 0; k < stall; k++) begin
            if (out_data !== o.od || out_cycles !== o.oc || out_timeout !== o.ot ||
                out_valid !== 1'b1 || in_ready !== 1'b0 || mul_data_in !== d) o.unstable++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready    = 1'b0;
        o.post_valid = out_valid;
        o.post_rdy   = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst: got %b expected 1", mul_rst); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        end
        checks++; if (mul_en !== 1'b0 || out_timeout !== 1'b0) begin errors++; $display("FAIL reset_en_to: got %b%b expected 00", mul_en, out_timeout); end
        checks++; if (out_data !== '0 || mul_data_in !== '0 || out_cycles !== '0) begin errors++; $display("FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", out_data, mul_data_in, out_cycles); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        checks++; if (mul_rst !== 1'b0) begin errors++; $display("FAIL reset_release_mul_rst: got %b expected 0", mul_rst); end
    endtask

    task automatic test_single();
        obs_t o;
        do_op({5'd4, 5'd3}, 10, 0, o);
        checks++; if (o.edges !== 14) begin errors++; $display("FAIL single_latency: got %0d expected 14", o.edges); end
        checks++; if (o.rst_c !== 2) begin errors++; $display("FAIL single_mul_rst_cycles: got %0d expected 2", o.rst_c); end
        checks++; if (o.en_c !== 10) begin errors++; $display("FAIL single_mul_en_cycles: got %0d expected 10", o.en_c); end
        checks++; if (o.od !== 10'd12) begin errors++; $display("FAIL single_out_data: got %0d expected 12", o.od); end
        checks++; if (o.oc !== 5'd10) begin errors++; $display("FAIL single_out_cycles: got %0d expected 10", o.oc); end
        checks++; if (o.ot !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", o.ot); end
        checks++; if (o.mdi !== {5'd4, 5'd3}) begin errors++; $display("FAIL single_mul_data_in: got %0d expected %0d", o.mdi, {5'd4, 5'd3}); end
        checks++; if (o.busy_rdy !== 0 || o.unstable !== 0) begin errors++; $display("FAIL single_busy: got ready=%0d unstable=%0d expected 0/0", o.busy_rdy, o.unstable); end
        checks++; if (o.post_valid !== 1'b0 || o.post_rdy !== 1'b1) begin errors++; $display("FAIL single_post: got valid=%b ready=%b expected 0/1", o.post_valid, o.post_rdy); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_op({5'd6, 5'd5}, 40, 1, o);
        checks++; if (o.ot !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", o.ot); end
        checks++; if (o.oc !== 5'd16) begin errors++; $display("FAIL timeout_cycles: got %0d expected 16", o.oc); end
        checks++; if (o.od !== 10'd16) begin errors++; $display("FAIL timeout_data: got %0d expected 16", o.od); end
        checks++; if (o.en_c !== 16) begin errors++; $display("FAIL timeout_en_cycles: got %0d expected 16", o.en_c); end
        do_op({5'd6, 5'd5}, 16, 0, o);
        checks++; if (o.ot !== 1'b0 || o.oc !== 5'd16) begin errors++; $display("FAIL limit_done_wins: got to=%b cyc=%0d expected 0/16", o.ot, o.oc); end
        checks++; if (o.od !== 10'd30) begin errors++; $display("FAIL limit_data: got %0d expected 30", o.od); end
        do_op({5'd2, 5'd3}, 1, 0, o);
        checks++; if (o.oc !== 5'd1 || o.ot !== 1'b0) begin errors++; $display("FAIL early_done: got cyc=%0d to=%b expected 1/0", o.oc, o.ot); end
        checks++; if (o.edges !== 5 || o.od !== 10'd6) begin errors++; $display("FAIL early_done_lat: got edges=%0d data=%0d expected 5/6", o.edges, o.od); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        do_op({5'd3, 5'd9}, 5, 5, o);
        checks++; if (o.unstable !== 0 || o.busy_rdy !== 0) begin errors++; $display("FAIL bp_stable: got unstable=%0d ready=%0d expected 0/0", o.unstable, o.busy_rdy); end
        checks++; if (o.od !== 10'd27) begin errors++; $display("FAIL bp_data: got %0d expected 27", o.od); end
        checks++; if (o.post_rdy !== 1'b1 || o.post_valid !== 1'b0) begin errors++; $display("FAIL bp_post: got ready=%b valid=%b expected 1/0", o.post_rdy, o.post_valid); end
        do_op({5'd7, 5'd7}, 8, 0, o);
        checks++; if (o.wait_rdy !== 0) begin errors++; $display("FAIL b2b_accept: got wait=%0d expected 0", o.wait_rdy); end
        checks++; if (o.od !== 10'd49 || o.oc !== 5'd8) begin errors++; $display("FAIL b2b_result: got %0d/%0d expected 49/8", o.od, o.oc); end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        int   en_seen;
        int   guard;
        int   ov_seen;
        int   l;
        model_lat  = 30;
        model_prod = ref_prod({5'd6, 5'd7});
        in_data    = {5'd6, 5'd7};
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        en_seen  = 0;
        guard    = 0;
        while (en_seen < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (mul_en) en_seen++;
        end
        checks++; if (en_seen !== 4) begin errors++; $display("FAIL midrst_reach_run: got %0d expected 4", en_seen); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mul_rst !== 1'b1 || mul_en !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got rst=%b en=%b expected 1/0", mul_rst, mul_en); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", in_ready); end
        ov_seen = 0;
        repeat (20) begin
            if (out_valid) ov_seen++;
            @(negedge clk);
        end
        checks++; if (ov_seen !== 0) begin errors++; $display("FAIL midrst_no_result: got %0d expected 0", ov_seen); end
        l = $urandom_range(1, 12);
        do_op({5'd2, 5'd5}, l, 0, o);
        checks++; if (o.od !== 10'd10 || o.ot !== 1'b0 || o.oc !== CW'(l)) begin errors++; $display("FAIL midrst_next: got %0d/%b/%0d expected 10/0/%0d", o.od, o.ot, o.oc, l); end
    endtask

    task automatic test_zero_bypass();
        obs_t o;
        do_op({5'd0, 5'd9}, 6, 0, o);
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
        checks++; if (o.edges !== 1 || o.en_c !== 0 || o.rst_c !== 0) begin errors++; $display("FAIL zero_bypass_path: got edges=%0d en=%0d rst=%0d expected 1/0/0", o.edges, o.en_c, o.rst_c); end
        checks++; if (o.oc !== 5'd0) begin errors++; $display("FAIL zero_bypass_cycles: got %0d expected 0", o.oc); end
`else
        checks++; if (o.edges !== 10 || o.en_c !== 6 || o.rst_c !== 2) begin errors++; $display("FAIL zero_full_path: got edges=%0d en=%0d rst=%0d expected 10/6/2", o.edges, o.en_c, o.rst_c); end
        checks++; if (o.oc !== 5'd6) begin errors++; $display("FAIL zero_full_cycles: got %0d expected 6", o.oc); end
`endif
        checks++; if (o.od !== 10'd0 || o.ot !== 1'b0) begin errors++; $display("FAIL zero_result: got %0d/%b expected 0/0", o.od, o.ot); end
        checks++; if (o.mdi !== {5'd0, 5'd9}) begin errors++; $display("FAIL zero_mul_data_in: got %0d expected %0d", o.mdi, {5'd0, 5'd9}); end
    endtask

    task automatic test_random();
        obs_t          o;
        logic [DW-1:0] d;
        logic [DW-1:0] e_data;
        logic          e_to;
        int            l, stall, e_edges, e_en, e_rst, e_cyc;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NI; i++) begin
                d[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 31));
            end
            l     = ($urandom_range(0, 5) == 0) ? 40 : $urandom_range(1, 20);
            stall = $urandom_range(0, 3);
            ref_op(d, l, e_edges, e_en, e_rst, e_data, e_cyc, e_to);
            do_op(d, l, stall, o);
            checks++; if (o.edges !== e_edges) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, o.edges, e_edges); end
            checks++; if (o.en_c !== e_en || o.rst_c !== e_rst) begin errors++; $display("FAIL rnd%0d_pulses: got en=%0d rst=%0d expected %0d/%0d", n, o.en_c, o.rst_c, e_en, e_rst); end
            checks++; if (o.od !== e_data) begin errors++; $display("FAIL rnd%0d_data: got %0d expected %0d", n, o.od, e_data); end
            checks++; if (o.oc !== CW'(e_cyc) || o.ot !== e_to) begin errors++; $display("FAIL rnd%0d_cyc_to: got %0d/%b expected %0d/%b", n, o.oc, o.ot, e_cyc, e_to); end
            checks++; if (o.mdi !== d || o.unstable !== 0 || o.busy_rdy !== 0) begin errors++; $display("FAIL rnd%0d_hold: got mdi=%0d unstable=%0d ready=%0d expected %0d/0/0", n, o.mdi, o.unstable, o.busy_rdy, d); end
            checks++; if (o.post_valid !== 1'b0 || o.post_rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_post: got valid=%b ready=%b expected 0/1", n, o.post_valid, o.post_rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_zero_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
